mips_bubble_ctrl: RTL



---
 rtl/mips_bubble_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mips_bubble_ctrl.sv
// ID-stage hazard/bubble controller: load-use stall sequencing, flush squash, hold freeze,
// registered ID/EX control bundle. Optional macro BUBBLE_CTRL_STATS_EN adds a bubble counter.
module mips_bubble_ctrl #(
  parameter int unsigned       CTRL_W     = 8,
  parameter int unsigned       STALL_CYC  = 1,
  parameter int unsigned       CNT_W      = 4,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic [4:0]        rs_id,
  input  logic [4:0]        rt_id,
  input  logic              uses_rt_id,
  input  logic              memread_ex,
  input  logic [4:0]        rt_ex,
  input  logic              flush,
  input  logic              hold,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
`ifdef BUBBLE_CTRL_STATS_EN
  output logic [31:0]       bubble_count,
`endif
  output logic              stall_active
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              haz_s;
  logic              bubble_inc_s;

  function automatic logic load_use_haz(
    input logic       memread,
    input logic [4:0] rt_load,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return memread & (rt_load != 5'd0) & ((rt_load == rs) | (uses_rt & (rt_load == rt)));
  endfunction

  assign haz_s   = load_use_haz(memread_ex, rt_ex, rs_id, rt_id, uses_rt_id);
  assign ctrl_ex = ctrl_q;

  // Next-state, next bundle and pipeline enables; flush beats hold beats hazard.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ctrl_d       = ctrl_q;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    stall_active = 1'b0;
    bubble_inc_s = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
    end else if (flush) begin
      ctrl_d       = BUBBLE_VAL;
      state_d      = RUN;
      cnt_d        = {CNT_W{1'b0}};
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b1;
      bubble_inc_s = 1'b1;
    end else if (hold) begin
      stall_active = (state_q == STALL);
    end else begin
      case (state_q)
        RUN: begin
          if (haz_s) begin
            stall_active = 1'b1;
            ctrl_d       = BUBBLE_VAL;
            bubble_inc_s = 1'b1;
            if (STALL_CYC == 1) begin
              state_d = RUN;
            end else begin
              state_d = STALL;
              cnt_d   = CNT_W'(STALL_CYC - 1);
            end
          end else begin
            ctrl_d     = ctrl_id;
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        STALL: begin
          // EX already holds a bubble here, so the hazard is not re-checked.
          stall_active = 1'b1;
          ctrl_d       = BUBBLE_VAL;
          bubble_inc_s = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = {CNT_W{1'b0}};
          ctrl_d  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // State, stall counter and ID/EX control register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= {CNT_W{1'b0}};
      ctrl_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef BUBBLE_CTRL_STATS_EN
  logic [31:0] bubble_count_q, bubble_count_d;

  // Saturating count of bubbles injected by hazard, stall or flush.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (bubble_inc_s && (bubble_count_q != 32'hFFFF_FFFF)) begin
      bubble_count_d = bubble_count_q + 32'd1;
    end else begin
      bubble_count_d = bubble_count_q;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count_q <= 32'd0;
    end else begin
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
`else
  logic unused_s;
  assign unused_s = bubble_inc_s;
`endif

endmodule
